multi_ultrasonic_ranger: RTL

//  Parametrised N-channel ultrasonic ranging engine; replaces the single-sensor sensor/timebase pair.

---
 rtl/multi_ultrasonic_ranger.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/multi_ultrasonic_ranger.sv
// N-channel round-robin ultrasonic ranger.
// Fires one sensor at a time, times its echo and streams the distance out.
module multi_ultrasonic_ranger #(
  parameter int NUM_CH      = 3,
  parameter int CNT_W       = 22,
  parameter int TRIG_CYCLES = 1000,
  parameter int TIMEOUT_CYC = 3_000_000,
  parameter int GAP_CYCLES  = 500_000,
  parameter int OBST_THRESH = 58_000,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] echo,
  output logic [NUM_CH-1:0] trigger,
  output logic              dist_valid,
  input  logic              dist_ready,
  output logic [CNT_W-1:0]  dist_data,
  output logic [CH_W-1:0]   dist_ch,
  output logic              dist_timeout,
  output logic [NUM_CH-1:0] obst,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    REPORT,
    GAP
  } state_e;

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO       = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] THR       = CNT_W'(OBST_THRESH);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

  state_e            state_q;
  logic [CH_W-1:0]   ch_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync2_q;
  logic [NUM_CH-1:0] trig_q;
  logic [NUM_CH-1:0] obst_q;
  logic              valid_q;
  logic              tmo_q;
  logic              busy_q;
  logic [CNT_W-1:0]  data_q;
  logic [CH_W-1:0]   dch_q;

  logic              echo_sel;
  logic              at_tmo;
  logic [CNT_W-1:0]  cnt_d;
  logic [CH_W-1:0]   ch_d;
  logic [NUM_CH-1:0] trig_d;

  // Selected echo, saturating counter step and next-channel trigger mask
  always_comb begin
    echo_sel = sync2_q[ch_q];
    at_tmo   = (cnt_q >= TMO);
    cnt_d    = at_tmo ? cnt_q : cnt_q + 1'b1;
    ch_d     = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
    trig_d   = NUM_CH'(1) << ch_d;
  end

  // Two-flop synchroniser on every raw echo pin
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= echo;
      sync2_q <= sync1_q;
    end
  end

  // Sequencer: trigger, time echo, hand off result, guard gap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      trig_q  <= '0;
      obst_q  <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      dch_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= TRIG;
            ch_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            trig_q  <= NUM_CH'(1);
          end
        end
        TRIG: begin
          if (cnt_q == TRIG_LAST) begin
            state_q <= WAIT_RISE;
            cnt_q   <= '0;
            trig_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_RISE: begin
          if (echo_sel) begin
            state_q <= MEASURE;
            cnt_q   <= CNT_W'(1);
          end else if (at_tmo) begin
            state_q      <= REPORT;
            valid_q      <= 1'b1;
            data_q       <= '1;
            dch_q        <= ch_q;
            tmo_q        <= 1'b1;
            obst_q[ch_q] <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        MEASURE: begin
          if (!echo_sel) begin
            state_q      <= REPORT;
            valid_q      <= 1'b1;
            data_q       <= cnt_q;
            dch_q        <= ch_q;
            tmo_q        <= 1'b0;
            obst_q[ch_q] <= (cnt_q < THR);
          end else if (at_tmo) begin
            state_q      <= REPORT;
            valid_q      <= 1'b1;
            data_q       <= '1;
            dch_q        <= ch_q;
            tmo_q        <= 1'b1;
            obst_q[ch_q] <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        REPORT: begin
          if (dist_ready) begin
            valid_q <= 1'b0;
            state_q <= GAP;
            cnt_q   <= '0;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            ch_q  <= ch_d;
            if (ch_q != CH_LAST) begin
              state_q <= TRIG;
              trig_q  <= trig_d;
            end else if (continuous) begin
              state_q <= TRIG;
              trig_q  <= trig_d;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign trigger      = trig_q;
  assign dist_valid   = valid_q;
  assign dist_data    = data_q;
  assign dist_ch      = dch_q;
  assign dist_timeout = tmo_q;
  assign obst         = obst_q;
  assign busy         = busy_q;

endmodule
